// File: rtl/output_drain_pkg.sv
// Shared types and helpers for the output drain controller.
package output_drain_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFlush,
        StDone
    } drain_state_t;

    // Width of a store index; at least one bit so single-store builds stay legal.
    function automatic int unsigned unit_idx_w(input int unsigned num_units);
        return (num_units > 1) ? $clog2(num_units) : 1;
    endfunction

endpackage

// File: rtl/output_drain_ctrl_skid.sv
// One-entry valid/ready output register holding a packed payload.
module output_drain_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/output_drain_ctrl.sv
// Drains NUM_UNITS per-unit output stores, in unit order, through a valid/ready port.
// Optional OUTPUT_DRAIN_LAST_EN adds out_last, flagging the final word of a drain.
`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 16
`endif
`ifndef BITS_OUTPUT_ADDR_PER_UNIT
`define BITS_OUTPUT_ADDR_PER_UNIT 4
`endif

module output_drain_ctrl
    import output_drain_pkg::*;
#(
    parameter int unsigned NUM_UNITS                 = 4,
    parameter int unsigned DATA_WIDTH                = `DATA_WIDTH_ADD_STG,
    parameter int unsigned BITS_OUTPUT_ADDR_PER_UNIT = `BITS_OUTPUT_ADDR_PER_UNIT
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [NUM_UNITS-1:0][BITS_OUTPUT_ADDR_PER_UNIT-1:0] unit_wr_addr,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]                unit_data_out,
    output logic [NUM_UNITS-1:0][BITS_OUTPUT_ADDR_PER_UNIT-1:0] unit_rd_addr,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [DATA_WIDTH-1:0]                                out_data,
    output logic [unit_idx_w(NUM_UNITS)-1:0]                     out_unit,
    output logic                                                 busy,
    output logic                                                 done
`ifdef OUTPUT_DRAIN_LAST_EN
    ,
    output logic                                                 out_last
`endif
);

    localparam int unsigned UW = unit_idx_w(NUM_UNITS);
    localparam int unsigned AW = BITS_OUTPUT_ADDR_PER_UNIT;
    localparam logic [UW-1:0] LastUnit = UW'(NUM_UNITS - 1);

    drain_state_t                 state_q;
    logic [NUM_UNITS-1:0][AW-1:0] count_q;
    logic [UW-1:0]                cur_unit_q;
    logic [AW-1:0]                rd_ptr_q;

    logic          out_free;
    logic          unit_empty;
    logic          unit_end;
    logic          push;
    logic [AW-1:0] rd_ptr_nxt;

    assign unit_empty = (count_q[cur_unit_q] == '0);
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign unit_end   = (rd_ptr_nxt == count_q[cur_unit_q]);
    assign push       = (state_q == StDrain) && !unit_empty && out_free;

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_rd_addr[i] = (int'(cur_unit_q) == i) ? rd_ptr_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            cur_unit_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        count_q    <= unit_wr_addr;
                        cur_unit_q <= '0;
                        rd_ptr_q   <= '0;
                        state_q    <= StDrain;
                    end
                end
                StDrain: begin
                    if (unit_empty || (out_free && unit_end)) begin
                        rd_ptr_q <= '0;
                        if (cur_unit_q == LastUnit) begin
                            state_q <= StFlush;
                        end else begin
                            cur_unit_q <= cur_unit_q + UW'(1);
                        end
                    end else if (out_free) begin
                        rd_ptr_q <= rd_ptr_nxt;
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef OUTPUT_DRAIN_LAST_EN
    localparam int unsigned PW = DATA_WIDTH + UW + 1;

    logic rest_empty;
    logic drain_last;

    // The final word is the end of this store with every later store empty.
    always_comb begin
        rest_empty = 1'b1;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (i > int'(cur_unit_q) && count_q[i] != '0) begin
                rest_empty = 1'b0;
            end
        end
    end
    assign drain_last = unit_end && rest_empty;

    logic [PW-1:0] payload_in;
    logic [PW-1:0] payload_out;
    assign payload_in = {drain_last, cur_unit_q, unit_data_out[cur_unit_q]};
    assign {out_last, out_unit, out_data} = payload_out;
`else
    localparam int unsigned PW = DATA_WIDTH + UW;

    logic [PW-1:0] payload_in;
    logic [PW-1:0] payload_out;
    assign payload_in = {cur_unit_q, unit_data_out[cur_unit_q]};
    assign {out_unit, out_data} = payload_out;
`endif

    output_drain_skid #(
        .Width(PW)
    ) u_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (push),
        .in_data_i  (payload_in),
        .in_ready_o (out_free),
        .out_valid_o(out_valid),
        .out_data_o (payload_out),
        .out_ready_i(out_ready)
    );

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Self-checking bench for output_drain_ctrl: vector table plus reset/restart sequences.
module tb_output_drain_ctrl;

    localparam int NU = 4;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int UW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [NU-1:0][AW-1:0]  unit_wr_addr;
    logic [NU-1:0][DW-1:0]  unit_data_out;
    logic [NU-1:0][AW-1:0]  unit_rd_addr;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [UW-1:0]          out_unit;
    logic                   busy;
    logic                   done;
`ifdef OUTPUT_DRAIN_LAST_EN
    logic                   out_last;
`endif

    output_drain_ctrl #(
        .NUM_UNITS                (NU),
        .DATA_WIDTH               (DW),
        .BITS_OUTPUT_ADDR_PER_UNIT(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .unit_wr_addr (unit_wr_addr),
        .unit_data_out(unit_data_out),
        .unit_rd_addr (unit_rd_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_unit     (out_unit),
        .busy         (busy),
        .done         (done)
`ifdef OUTPUT_DRAIN_LAST_EN
        ,
        .out_last     (out_last)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_word(input int u, input logic [AW-1:0] a);
        return {4'(u + 1), 8'h5C, a};
    endfunction

    // Store model: combinational read data tagged with store index and address.
    always_comb begin
        for (int u = 0; u < NU; u++) begin
            unit_data_out[u] = mk_word(u, unit_rd_addr[u]);
        end
    end

    typedef struct packed {
        logic [UW-1:0] unit;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [NU-1:0][AW-1:0] counts;
        logic [3:0]            rdy;
        bit                    poke;
        int                    exp_words;
        int                    exp_cycles;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[6];
    int    n_vec = 0;
    int    n_bad = 0;
    int    n_words;
    bit    busy_low;
    bit    stalled_prev;
    logic [UW+DW-1:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NU-1:0][AW-1:0] mkc(input int a, input int b, input int c,
                                                  input int d);
        logic [NU-1:0][AW-1:0] r;
        r[0] = AW'(a);
        r[1] = AW'(b);
        r[2] = AW'(c);
        r[3] = AW'(d);
        return r;
    endfunction

    task automatic push_expected(input logic [NU-1:0][AW-1:0] counts);
        exp_t e;
        for (int u = 0; u < NU; u++) begin
            for (int a = 0; a < int'(counts[u]); a++) begin
                e.unit = UW'(u);
                e.data = mk_word(u, AW'(a));
                e.last = 1'b0;
                sb.push_back(e);
            end
        end
        if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    endtask

    // Called just after an edge: drive ready, score any word accepted at the coming edge.
    task automatic cycle(input logic rdy);
        exp_t e;
        out_ready = rdy;
        if (stalled_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'({out_unit, out_data}), 32'(held));
        end
        if (out_valid && rdy) begin
            n_words++;
            if (sb.size() == 0) begin
                check("extra_word", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("word_unit", 32'(out_unit), 32'(e.unit));
                check("word_data", 32'(out_data), 32'(e.data));
`ifdef OUTPUT_DRAIN_LAST_EN
                check("word_last", 32'(out_last), 32'(e.last));
`endif
            end
        end
        stalled_prev = out_valid && !rdy;
        held = {out_unit, out_data};
        @(posedge clk);
        #1;
    endtask

    task automatic run_drain(input vec_t v, input bit check_lat);
        int k;
        n_words      = 0;
        busy_low     = 1'b0;
        stalled_prev = 1'b0;
        push_expected(v.counts);
        unit_wr_addr = v.counts;
        start        = 1'b1;
        out_ready    = v.rdy[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        if (check_lat) check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 200) begin
            if (check_lat && k == 1) check("lat_cycle2_valid", 32'(out_valid), 32'd1);
            if (v.poke && k == 3) begin
                start        = 1'b1;
                unit_wr_addr = '1;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_low = 1'b1;
            cycle(v.rdy[k % 4]);
            k++;
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_until_done", 32'(busy_low), 32'd0);
        if (v.exp_cycles != 0) check("cycles_to_done", 32'(k), 32'(v.exp_cycles));
        check("word_count", 32'(n_words), 32'(v.exp_words));
        check("sb_empty", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{counts: mkc(3, 0, 2, 1), rdy: 4'b1111, poke: 1'b0, exp_words: 6,
                    exp_cycles: 8};
        vecs[1] = '{counts: mkc(3, 0, 2, 1), rdy: 4'b0101, poke: 1'b0, exp_words: 6,
                    exp_cycles: 0};
        vecs[2] = '{counts: mkc(0, 0, 0, 0), rdy: 4'b1111, poke: 1'b0, exp_words: 0,
                    exp_cycles: 5};
        vecs[3] = '{counts: mkc(3, 0, 2, 1), rdy: 4'b1111, poke: 1'b1, exp_words: 6,
                    exp_cycles: 8};
        vecs[4] = '{counts: mkc(1, 1, 1, 1), rdy: 4'b0110, poke: 1'b0, exp_words: 4,
                    exp_cycles: 0};
        vecs[5] = '{counts: mkc(15, 0, 0, 2), rdy: 4'b1111, poke: 1'b0, exp_words: 17,
                    exp_cycles: 20};

        rst          = 1'b1;
        start        = 1'b0;
        out_ready    = 1'b0;
        unit_wr_addr = mkc(2, 2, 2, 2);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_unit", 32'(out_unit), 32'd0);
        check("rst_rd_addr", 32'(unit_rd_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_drain(vecs[i], i == 0);
        end

        // Reset after the third accepted word, then replay the full drain.
        n_words      = 0;
        stalled_prev = 1'b0;
        push_expected(vecs[0].counts);
        unit_wr_addr = vecs[0].counts;
        start        = 1'b1;
        out_ready    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (n_words < 3 && k < 50) begin
            cycle(1'b1);
            k++;
        end
        check("pre_reset_words", 32'(n_words), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_rd_addr", 32'(unit_rd_addr), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_idle_busy", 32'(busy), 32'd0);
        run_drain(vecs[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/output_drain_ctrl.md
OUTPUT_DRAIN_CTRL -- requirements
Module: output_drain_ctrl

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of per-unit output stores drained.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH_ADD_STG, word width of each store.
REQ-003 SHALL have parameter BITS_OUTPUT_ADDR_PER_UNIT, default `BITS_OUTPUT_ADDR_PER_UNIT, store address width.
REQ-004 Ports, in this order:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse requesting a drain of all stores.
- unit_wr_addr  in  NUM_UNITS x BITS_OUTPUT_ADDR_PER_UNIT  per-store word count (write pointer).
- unit_data_out  in  NUM_UNITS x DATA_WIDTH  per-store combinational read data for unit_rd_addr.
- unit_rd_addr  out  NUM_UNITS x BITS_OUTPUT_ADDR_PER_UNIT  per-store read address.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
- out_data  out  DATA_WIDTH  drained word.
- out_unit  out  $clog2(NUM_UNITS)  index of the store out_data came from.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the drain completes.

Function
REQ-005 FSM states: IDLE, DRAIN, FLUSH, DONE.
REQ-006 IDLE: start=1 latches all unit_wr_addr values into count registers, clears cur_unit and rd_ptr, enters DRAIN next cycle.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 DRAIN: if count[cur_unit]==0, advance cur_unit with no output (one bubble cycle per empty store).
REQ-009 DRAIN: if the output register is free (out_valid==0, or out_valid&&out_ready), capture unit_data_out[cur_unit] into out_data, set out_unit=cur_unit and out_valid=1 at the next edge, and increment rd_ptr.
REQ-010 When rd_ptr reaches count[cur_unit], rd_ptr SHALL clear and cur_unit increment; after the last store, go to FLUSH.
REQ-011 unit_rd_addr[cur_unit] SHALL equal rd_ptr; all other stores SHALL be driven 0.
REQ-012 FLUSH: wait until out_valid==0, or out_valid&&out_ready; then go to DONE.
REQ-013 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-014 Latency: first out_valid 2 cycles after start is sampled.
REQ-015 Throughput: with out_ready held high, one word per cycle.
REQ-016 out_valid=1 && out_ready=0 SHALL hold out_data, out_unit and out_valid stable, and rd_ptr SHALL not advance.
REQ-017 If all counts are 0 at start: IDLE -> DRAIN (NUM_UNITS bubbles) -> FLUSH -> DONE; out_valid never asserted.
REQ-018 Counts are the values latched at start; later unit_wr_addr changes SHALL be ignored until the next start.

Reset
REQ-019 rst=1 at any edge, including mid-drain, SHALL force IDLE, clear all counts, cur_unit, rd_ptr and out_unit, set out_valid=0, done=0, busy=0, out_data=0, unit_rd_addr=0; in-flight words are discarded.

Configuration
REQ-020 Macro OUTPUT_DRAIN_LAST_EN defined: add output port out_last (1 bit), high with out_valid on the final word of the whole drain, reset 0.
REQ-021 Macro OUTPUT_DRAIN_LAST_EN undefined: port out_last absent; all other behaviour identical.

Structure
REQ-022 Package output_drain_pkg SHALL hold the FSM state enum (drain_state_t) and the unit index width function/constant.
REQ-023 One sub-module SHALL hold the one-entry valid/ready output register: output_drain_skid.

Verification
REQ-024 NUM_UNITS=4, counts {3,0,2,1}, out_ready=1, start -> 6 words in order unit 0 addr 0,1,2, unit 2 addr 0,1, unit 3 addr 0; first out_valid 2 cycles after start; one bubble for unit 1; done pulses once.
REQ-025 Same drain with out_ready toggling 1,0,1,0 -> identical word sequence, no duplicates or drops, out_data stable while stalled.
REQ-026 All counts 0, start -> out_valid stays 0; done pulses; busy high from the cycle after start until done.
REQ-027 start re-pulsed mid-drain and unit_wr_addr changed mid-drain -> ignored; word count equals the latched counts.
REQ-028 rst=1 after the 3rd accepted word of scenario REQ-024 -> next cycle IDLE, out_valid=0, busy=0; a fresh start replays the full sequence.
REQ-029 OUTPUT_DRAIN_LAST_EN defined, scenario REQ-024 -> out_last=1 only with unit 3 addr 0.
